range_stats_finder: RTL and testbench

- Parametrised successor to the single-width range finder, with the same go/finish sequence protocol.
- Tracks min, max, range and sample count over a framed sequence of samples.
- Adds a data_valid qualifier for gapped streams, signed/unsigned compare mode, a sample counter with overflow detection and a one-cycle done pulse.
- Sits between the input pins and a result register/readback path; all results are registered and held until the next sequence completes.

---
 rtl/range_stats_finder_pkg.sv | 24 ++
 rtl/range_stats_finder_if.sv | 29 ++
 rtl/range_stats_finder_datapath.sv | 73 +++++++
 rtl/range_stats_finder.sv | 112 +++++++++++
 tb/tb_range_stats_finder.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/range_stats_finder_pkg.sv
// Shared types and helpers for the range/statistics finder.
// Holds the FSM state encoding and a sign-aware compare helper.
package range_stats_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StError = 2'd2,
    StDone  = 2'd3
  } state_e;

  // Operands are pre-extended to this width so one helper serves any WIDTH up to 64.
  localparam int unsigned MaxWidth = 64;

  function automatic logic less_than(input logic [MaxWidth-1:0] a,
                                     input logic [MaxWidth-1:0] b,
                                     input bit                  is_signed);
    if (is_signed) begin
      return $signed(a) < $signed(b);
    end
    return a < b;
  endfunction

endpackage

// File: rtl/range_stats_finder_if.sv
// Sample/control and result bundle for range_stats_finder.
// The master side drives samples and framing; the slave side returns held results.
interface range_stats_finder_if #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned CNT_WIDTH = 8
);

  logic [WIDTH-1:0]     data_in;
  logic                 data_valid;
  logic                 go;
  logic                 finish;
  logic [WIDTH-1:0]     range;
  logic [WIDTH-1:0]     min_out;
  logic [WIDTH-1:0]     max_out;
  logic [CNT_WIDTH-1:0] count;
  logic                 done;
  logic                 error;

  modport master (
    output data_in, data_valid, go, finish,
    input  range, min_out, max_out, count, done, error
  );

  modport slave (
    input  data_in, data_valid, go, finish,
    output range, min_out, max_out, count, done, error
  );

endinterface

// File: rtl/range_stats_finder_datapath.sv
// Working min/max/count registers with their next-value compare logic.
// load_i starts a fresh sequence from data_i; update_i folds data_i into the running values.
module range_stats_datapath
  import range_stats_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned CNT_WIDTH = 8,
  parameter bit          SIGNED    = 1'b0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 load_i,
  input  logic                 update_i,
  input  logic [WIDTH-1:0]     data_i,
  output logic [WIDTH-1:0]     min_next_o,
  output logic [WIDTH-1:0]     max_next_o,
  output logic [CNT_WIDTH-1:0] cnt_next_o,
  output logic                 cnt_full_o
);

  logic [WIDTH-1:0]     min_q, min_d;
  logic [WIDTH-1:0]     max_q, max_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [MaxWidth-1:0]  data_x, min_x, max_x;
  logic                 is_lower, is_higher;

  if (SIGNED) begin : g_sext
    assign data_x = MaxWidth'($signed(data_i));
    assign min_x  = MaxWidth'($signed(min_q));
    assign max_x  = MaxWidth'($signed(max_q));
  end else begin : g_zext
    assign data_x = MaxWidth'(data_i);
    assign min_x  = MaxWidth'(min_q);
    assign max_x  = MaxWidth'(max_q);
  end

  // Strict compares: equal samples leave min/max untouched.
  assign is_lower  = less_than(data_x, min_x, SIGNED);
  assign is_higher = less_than(max_x, data_x, SIGNED);

  always_comb begin
    min_d = min_q;
    max_d = max_q;
    cnt_d = cnt_q;
    if (load_i) begin
      min_d = data_i;
      max_d = data_i;
      cnt_d = CNT_WIDTH'(1);
    end else if (update_i) begin
      if (is_lower)  min_d = data_i;
      if (is_higher) max_d = data_i;
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      min_q <= '0;
      max_q <= '0;
      cnt_q <= '0;
    end else begin
      min_q <= min_d;
      max_q <= max_d;
      cnt_q <= cnt_d;
    end
  end

  assign min_next_o = min_d;
  assign max_next_o = max_d;
  assign cnt_next_o = cnt_d;
  assign cnt_full_o = (cnt_q == {CNT_WIDTH{1'b1}});

endmodule

// File: rtl/range_stats_finder.sv
// Framed min/max/range/count tracker with go/finish sequencing.
// Results are registered on a clean finish and held until the next one or reset.
module range_stats_finder
  import range_stats_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned CNT_WIDTH = 8,
  parameter bit          SIGNED    = 1'b0
) (
  input  logic                clock,
  input  logic                reset,
  range_stats_finder_if.slave bus
);

  state_e state_q, state_d;
  logic   load, update, write_res;

  logic [WIDTH-1:0]     min_next, max_next;
  logic [CNT_WIDTH-1:0] cnt_next;
  logic                 cnt_full;

  logic [WIDTH-1:0]     range_q, min_q, max_q;
  logic [CNT_WIDTH-1:0] count_q;

  range_stats_datapath #(
    .WIDTH     (WIDTH),
    .CNT_WIDTH (CNT_WIDTH),
    .SIGNED    (SIGNED)
  ) u_datapath (
    .clk_i      (clock),
    .rst_i      (reset),
    .load_i     (load),
    .update_i   (update),
    .data_i     (bus.data_in),
    .min_next_o (min_next),
    .max_next_o (max_next),
    .cnt_next_o (cnt_next),
    .cnt_full_o (cnt_full)
  );

  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    update    = 1'b0;
    write_res = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.finish) begin
          state_d = StError;
        end else if (bus.go) begin
          load    = 1'b1;
          state_d = StRun;
        end
      end
      StRun: begin
        if (bus.go) begin
          state_d = StError;
        end else if (bus.data_valid && cnt_full) begin
          // Overflow wins over finish: nothing is written.
          state_d = StError;
        end else begin
          update = bus.data_valid;
          if (bus.finish) begin
            write_res = 1'b1;
            state_d   = StDone;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      StError: begin
        if (bus.go && !bus.finish) begin
          load    = 1'b1;
          state_d = StRun;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Results come from the datapath next-values so the finish sample is included.
  always_ff @(posedge clock) begin
    if (reset) begin
      range_q <= '0;
      min_q   <= '0;
      max_q   <= '0;
      count_q <= '0;
    end else if (write_res) begin
      range_q <= max_next - min_next;
      min_q   <= min_next;
      max_q   <= max_next;
      count_q <= cnt_next;
    end
  end

  assign bus.range   = range_q;
  assign bus.min_out = min_q;
  assign bus.max_out = max_q;
  assign bus.count   = count_q;
  assign bus.done    = (state_q == StDone);
  assign bus.error   = (state_q == StError);

endmodule

// File: tb/tb_range_stats_finder.sv
// Directed bench for range_stats_finder: unsigned, signed and narrow-counter instances
// driven in one linear sequence, with expected results queued at finish and checked at done.
module tb_range_stats_finder;

  logic clock;
  logic reset;

  range_stats_finder_if #(.WIDTH(8), .CNT_WIDTH(8)) if_a ();
  range_stats_finder_if #(.WIDTH(8), .CNT_WIDTH(8)) if_s ();
  range_stats_finder_if #(.WIDTH(8), .CNT_WIDTH(3)) if_c ();

  range_stats_finder #(.WIDTH(8), .CNT_WIDTH(8), .SIGNED(1'b0)) u_dut_a (
    .clock (clock),
    .reset (reset),
    .bus   (if_a)
  );

  range_stats_finder #(.WIDTH(8), .CNT_WIDTH(8), .SIGNED(1'b1)) u_dut_s (
    .clock (clock),
    .reset (reset),
    .bus   (if_s)
  );

  range_stats_finder #(.WIDTH(8), .CNT_WIDTH(3), .SIGNED(1'b0)) u_dut_c (
    .clock (clock),
    .reset (reset),
    .bus   (if_c)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int          id;
    logic [31:0] mn;
    logic [31:0] mx;
    logic [31:0] rg;
    logic [31:0] ct;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  localparam int DutA = 0;
  localparam int DutS = 1;
  localparam int DutC = 2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int id, input bit g, input bit f, input bit v, input logic [7:0] d);
    if_a.go = 1'b0; if_a.finish = 1'b0; if_a.data_valid = 1'b0; if_a.data_in = '0;
    if_s.go = 1'b0; if_s.finish = 1'b0; if_s.data_valid = 1'b0; if_s.data_in = '0;
    if_c.go = 1'b0; if_c.finish = 1'b0; if_c.data_valid = 1'b0; if_c.data_in = '0;
    case (id)
      DutA: begin if_a.go = g; if_a.finish = f; if_a.data_valid = v; if_a.data_in = d; end
      DutS: begin if_s.go = g; if_s.finish = f; if_s.data_valid = v; if_s.data_in = d; end
      default: begin if_c.go = g; if_c.finish = f; if_c.data_valid = v; if_c.data_in = d; end
    endcase
    @(posedge clock);
    #1;
  endtask

  task automatic push(input int id, input logic [31:0] mn, input logic [31:0] mx,
                      input logic [31:0] ct);
    exp_t e;
    e.id = id;
    e.mn = mn;
    e.mx = mx;
    e.rg = (mx - mn) & 32'hFF;
    e.ct = ct;
    sb_q.push_back(e);
  endtask

  task automatic get_obs(input int id, output logic [31:0] mn, output logic [31:0] mx,
                         output logic [31:0] rg, output logic [31:0] ct,
                         output logic [31:0] dn, output logic [31:0] er);
    case (id)
      DutA: begin
        mn = 32'(if_a.min_out); mx = 32'(if_a.max_out); rg = 32'(if_a.range);
        ct = 32'(if_a.count); dn = 32'(if_a.done); er = 32'(if_a.error);
      end
      DutS: begin
        mn = 32'(if_s.min_out); mx = 32'(if_s.max_out); rg = 32'(if_s.range);
        ct = 32'(if_s.count); dn = 32'(if_s.done); er = 32'(if_s.error);
      end
      default: begin
        mn = 32'(if_c.min_out); mx = 32'(if_c.max_out); rg = 32'(if_c.range);
        ct = 32'(if_c.count); dn = 32'(if_c.done); er = 32'(if_c.error);
      end
    endcase
  endtask

  // Called on the cycle after a finish edge: done must be high and results must match.
  task automatic check_result(input int id, input string tag);
    exp_t e;
    logic [31:0] mn, mx, rg, ct, dn, er;
    get_obs(id, mn, mx, rg, ct, dn, er);
    chk({tag, "_sb_nonempty"}, 32'(sb_q.size() > 0), 32'd1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk({tag, "_id"}, 32'(e.id), 32'(id));
      chk({tag, "_done"}, dn, 32'd1);
      chk({tag, "_min"}, mn, e.mn);
      chk({tag, "_max"}, mx, e.mx);
      chk({tag, "_range"}, rg, e.rg);
      chk({tag, "_count"}, ct, e.ct);
    end
  endtask

  task automatic check_flags(input int id, input string tag, input logic [31:0] exp_done,
                             input logic [31:0] exp_err, input logic [31:0] exp_rg,
                             input logic [31:0] exp_ct);
    logic [31:0] mn, mx, rg, ct, dn, er;
    get_obs(id, mn, mx, rg, ct, dn, er);
    chk({tag, "_done"}, dn, exp_done);
    chk({tag, "_error"}, er, exp_err);
    chk({tag, "_range"}, rg, exp_rg);
    chk({tag, "_count"}, ct, exp_ct);
  endtask

  initial begin
    reset = 1'b1;
    step(DutA, 0, 0, 0, 8'd0);
    step(DutA, 0, 0, 0, 8'd0);
    reset = 1'b0;
    check_flags(DutA, "reset_a", 0, 0, 0, 0);
    check_flags(DutC, "reset_c", 0, 0, 0, 0);
    chk("reset_min", 32'(if_a.min_out), 32'd0);
    chk("reset_max", 32'(if_a.max_out), 32'd0);

    // Basic unsigned sequence
    step(DutA, 1, 0, 0, 8'd20);
    step(DutA, 0, 0, 1, 8'd5);
    step(DutA, 0, 0, 1, 8'd200);
    step(DutA, 0, 0, 1, 8'd7);
    step(DutA, 0, 1, 1, 8'd9);
    push(DutA, 5, 200, 5);
    check_result(DutA, "basic");
    step(DutA, 0, 0, 0, 8'd0);
    check_flags(DutA, "basic_after", 0, 0, 195, 5);

    // Gapped stream: invalid extremes must be ignored
    step(DutA, 1, 0, 0, 8'd50);
    step(DutA, 0, 0, 0, 8'd0);
    step(DutA, 0, 0, 0, 8'd255);
    step(DutA, 0, 0, 1, 8'd60);
    step(DutA, 0, 1, 0, 8'd255);
    push(DutA, 50, 60, 2);
    check_result(DutA, "gapped");
    step(DutA, 0, 0, 0, 8'd0);

    // Error paths
    step(DutA, 0, 1, 0, 8'd0);
    check_flags(DutA, "fin_idle", 0, 1, 10, 2);
    step(DutA, 1, 0, 0, 8'd1);
    check_flags(DutA, "err_restart", 0, 0, 10, 2);
    step(DutA, 1, 0, 0, 8'd3);
    check_flags(DutA, "go_in_run", 0, 1, 10, 2);
    step(DutA, 1, 1, 0, 8'd4);
    check_flags(DutA, "go_fin_err", 0, 1, 10, 2);
    step(DutA, 1, 0, 0, 8'd8);
    step(DutA, 0, 1, 1, 8'd8);
    push(DutA, 8, 8, 2);
    check_result(DutA, "equal");
    chk("equal_error", 32'(if_a.error), 32'd0);
    step(DutA, 0, 0, 0, 8'd0);

    // Reset mid-sequence
    step(DutA, 1, 0, 0, 8'd99);
    step(DutA, 0, 0, 1, 8'd3);
    reset = 1'b1;
    step(DutA, 0, 0, 1, 8'd250);
    reset = 1'b0;
    check_flags(DutA, "mid_reset", 0, 0, 0, 0);
    chk("mid_reset_max", 32'(if_a.max_out), 32'd0);
    step(DutA, 1, 0, 0, 8'd42);
    step(DutA, 0, 1, 0, 8'd0);
    push(DutA, 42, 42, 1);
    check_result(DutA, "single");
    step(DutA, 0, 0, 0, 8'd0);

    // Signed compare
    step(DutS, 1, 0, 0, 8'h9C);
    step(DutS, 0, 0, 1, 8'd27);
    step(DutS, 0, 1, 1, 8'hFB);
    push(DutS, 32'h9C, 32'd27, 3);
    check_result(DutS, "signed");
    step(DutS, 0, 0, 0, 8'd0);

    // Narrow counter: prior result, then a full legal 7-sample sequence
    step(DutC, 1, 0, 0, 8'd4);
    step(DutC, 0, 1, 1, 8'd9);
    push(DutC, 4, 9, 2);
    check_result(DutC, "c_first");
    step(DutC, 0, 0, 0, 8'd0);
    step(DutC, 1, 0, 0, 8'd1);
    for (int i = 2; i <= 6; i++) step(DutC, 0, 0, 1, 8'(i));
    step(DutC, 0, 1, 1, 8'd7);
    push(DutC, 1, 7, 7);
    check_result(DutC, "c_full");
    step(DutC, 0, 0, 0, 8'd0);

    // Overflow on the 8th sample
    step(DutC, 1, 0, 0, 8'd1);
    for (int i = 2; i <= 7; i++) step(DutC, 0, 0, 1, 8'(i));
    check_flags(DutC, "c_at_max", 0, 0, 6, 7);
    step(DutC, 0, 0, 1, 8'd8);
    check_flags(DutC, "c_ovf", 0, 1, 6, 7);
    step(DutC, 0, 0, 0, 8'd0);
    check_flags(DutC, "c_ovf_hold", 0, 1, 6, 7);

    // Overflow together with finish still errors and writes nothing
    step(DutC, 1, 0, 0, 8'd2);
    for (int i = 0; i < 6; i++) step(DutC, 0, 0, 1, 8'd3);
    step(DutC, 0, 1, 1, 8'd30);
    check_flags(DutC, "c_ovf_fin", 0, 1, 6, 7);

    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
